// File: rtl/mem_loader.sv
// Serial boot loader: parses SYNC/ADDR/LEN/DATA/CHK frames from a UART byte
// stream and writes the assembled 16-bit words through memory port 2.
module mem_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [23:0] TIMEOUT   = 24'd1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        write_enable2,
  output logic [15:0] addr2,
  output logic [15:0] data_in2,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA_LO, S_DATA_HI, S_CHECK
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [15:0] r_base;
  logic [15:0] r_len;
  logic [15:0] r_idx;
  logic [7:0]  r_lo;
  logic [7:0]  r_chk;
  logic [23:0] r_timer;
  logic        r_we;
  logic [15:0] r_addr;
  logic [15:0] r_data;
  logic        r_done;
  logic        r_error;

  logic        w_busy;
  logic        w_sync;
  logic        w_word;
  logic        w_check;
  logic        w_timeout;
  logic [15:0] w_idx_inc;
  logic [15:0] w_len_full;

  assign w_idx_inc  = r_idx + 16'd1;
  assign w_len_full = {r_len[15:8], rx_data};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; timeout overrides any pending transition
  always_comb begin
    w_next = r_state;
    if (rx_valid) begin
      case (r_state)
        S_IDLE:    if (rx_data == SYNC_BYTE) w_next = S_ADDR_H;
        S_ADDR_H:  w_next = S_ADDR_L;
        S_ADDR_L:  w_next = S_LEN_H;
        S_LEN_H:   w_next = S_LEN_L;
        S_LEN_L:   w_next = (w_len_full == 16'd0) ? S_CHECK : S_DATA_LO;
        S_DATA_LO: w_next = S_DATA_HI;
        S_DATA_HI: w_next = (w_idx_inc == r_len) ? S_CHECK : S_DATA_LO;
        S_CHECK:   w_next = S_IDLE;
        default:   w_next = S_IDLE;
      endcase
    end
    if (w_timeout) begin
      w_next = S_IDLE;
    end
  end

  // Output / event decode
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_sync    = (r_state == S_IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    w_word    = (r_state == S_DATA_HI) && rx_valid;
    w_check   = (r_state == S_CHECK) && rx_valid;
    w_timeout = w_busy && !rx_valid && (r_timer == TIMEOUT - 24'd1);
  end

  // Frame datapath: header fields, word assembly, checksum and idle timer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_base  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_lo    <= '0;
      r_chk   <= '0;
      r_timer <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_we   <= w_word;
      r_done <= w_check && (rx_data == r_chk);

      if (!w_busy || rx_valid) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + 24'd1;
      end

      if (w_word) begin
        r_addr <= r_base + r_idx;
        r_data <= {rx_data, r_lo};
        r_idx  <= w_idx_inc;
      end

      if (rx_valid) begin
        case (r_state)
          S_ADDR_H:  r_base[15:8] <= rx_data;
          S_ADDR_L:  r_base[7:0]  <= rx_data;
          S_LEN_H:   r_len[15:8]  <= rx_data;
          S_LEN_L:   r_len[7:0]   <= rx_data;
          S_DATA_LO: begin
            r_lo  <= rx_data;
            r_chk <= r_chk + rx_data;
          end
          S_DATA_HI: r_chk <= r_chk + rx_data;
          default: ;
        endcase
      end

      if (w_sync) begin
        r_error <= 1'b0;
        r_chk   <= '0;
        r_idx   <= '0;
      end else if (w_timeout || (w_check && (rx_data != r_chk))) begin
        r_error <= 1'b1;
      end
    end
  end

  assign write_enable2 = r_we;
  assign addr2         = r_addr;
  assign data_in2      = r_data;
  assign cpu_hold      = w_busy;
  assign busy          = w_busy;
  assign done          = r_done;
  assign error         = r_error;

endmodule

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Serial boot loader upstream of memory port 2. Consumes a byte stream from the UART receiver, parses a framed load command and assembles 16-bit words.
- Writes each word through the memory's second port: `write_enable2`, `addr2`, `data_in2`.
- Holds the CPU while a load is in progress and reports completion or error.
- Allows program images to be loaded without resynthesising the memory init file.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 24'd1000000, maximum idle cycles between bytes inside a frame before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- rx_data  in  8  received byte from UART
- rx_valid  in  1  one-cycle strobe, rx_data valid; may assert on consecutive cycles
- write_enable2  out  1  memory port-2 write strobe
- addr2  out  16  memory port-2 word address
- data_in2  out  16  memory port-2 write data
- cpu_hold  out  1  high while a frame is being received; CPU stalled/held
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse on successful frame end
- error  out  1  sticky; set on checksum mismatch or timeout, cleared on next accepted SYNC_BYTE

Behaviour:
- Reset: one clock; `rst` is asynchronous and active-low.
  - While `rst` is low, state=IDLE and every output is 0: `write_enable2`, `addr2`, `data_in2`, `cpu_hold`, `busy`, `done`, `error`.
  - All internal registers (base, count, checksum, timer) are cleared.
  - Reset mid-frame abandons the frame; words already written stay in memory.
- Frame format, in byte order:
  - SYNC
  - ADDR_H, ADDR_L (16-bit word base address)
  - LEN_H, LEN_L (16-bit word count N)
  - 2N data bytes, low byte first, then high byte, per word
  - CHK = 8-bit sum mod 256 of all 2N data bytes
- States: IDLE, ADDR_H, ADDR_L, LEN_H, LEN_L, DATA_LO, DATA_HI, CHECK. All transitions occur only on `rx_valid`, except timeout.
- IDLE:
  - Bytes other than SYNC_BYTE are ignored.
  - SYNC_BYTE → ADDR_H, clear `error`, clear checksum, set `cpu_hold` and `busy` next cycle.
- ADDR_H → ADDR_L → LEN_H → LEN_L: each state latches its byte.
  - From LEN_L: N=0 → CHECK, else → DATA_LO.
- DATA_LO: latch the low byte, add it to the checksum → DATA_HI.
- DATA_HI: add the byte to the checksum.
  - On the cycle after this `rx_valid`: `write_enable2`=1 for exactly one cycle, `addr2`=base+index, `data_in2`={hi,lo}.
  - Then index+1. Go to CHECK if index+1==N, else to DATA_LO.
- Address arithmetic is 16-bit and wraps: base 16'hFFFF, index 1 → `addr2` 16'h0000.
- `addr2` and `data_in2` hold their last values when `write_enable2`=0.
- CHECK, on the received byte:
  - Match → `done` pulses 1 cycle (the cycle after `rx_valid`).
  - Mismatch → `error`=1, no `done` pulse.
  - Either way → IDLE; `cpu_hold` and `busy` drop in the same cycle `done`/`error` appears.
- Timeout:
  - The cycle counter resets on every `rx_valid` and on entry from IDLE.
  - In any non-IDLE state, if the counter reaches TIMEOUT: `error`=1, go to IDLE, drop `cpu_hold`. No partial word is written.
- SYNC_BYTE appearing inside a frame is treated as ordinary data, not a restart.
- `rx_valid` on consecutive cycles must be accepted without loss. The write for word k overlaps reception of word k+1's low byte.
- Memory port 2 has no backpressure; `write_enable2` is never held more than one cycle.

Test Plan:
- Basic load:
  - Stimulus: A5 10 00 00 02 34 12 78 56 14.
  - Expected: writes (0x1000, 0x1234) then (0x1001, 0x5678). `done` pulses once, `error`=0. `cpu_hold` high from the cycle after A5 until the cycle after 14.
- Zero length:
  - Stimulus: A5 20 00 00 00 00.
  - Expected: no write, `done`=1.
  - Follow-up: A5 20 00 00 00 01 → `error`=1, no `done`.
- Checksum mismatch:
  - Stimulus: basic frame with CHK=15.
  - Expected: both writes still occur, `error`=1, `done`=0, `cpu_hold` drops.
  - Follow-up: next A5 clears `error`.
- Address wrap with back-to-back strobes:
  - Stimulus: A5 FF FF 00 02 01 00 02 00 03, with `rx_valid` every cycle.
  - Expected: writes (0xFFFF, 0x0001) and (0x0000, 0x0002), `done`.
- Timeout:
  - Stimulus: A5 10 00 00 01 34, then silence for TIMEOUT cycles.
  - Expected: `error`=1, state IDLE, no write.
  - Follow-up: a subsequent valid frame succeeds.
- Noise and reset:
  - Stimulus: bytes 00 FF 5A in IDLE; then `rst` low after ADDR_L of a frame.
  - Expected: the noise bytes are ignored with outputs unchanged. On reset, all outputs go 0 immediately. Bytes arriving before A5 are ignored.
